// File: rtl/fetch_sequencer32.sv
// Instruction-fetch controller: owns the PC, reads a combinational instruction memory and
// buffers fetched words in a 2-entry prefetch FIFO handed to decode over valid/ready.
module fetch_sequencer32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_fault,
  output logic [1:0]  fetch_state
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StHalted = 2'd1,
    StFault  = 2'd2
  } state_e;

  localparam logic [1:0] Full = 2'(DEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [31:0] ent_inst_q [2];
  logic [31:0] ent_inst_d [2];
  logic [31:0] ent_pc_q   [2];
  logic [31:0] ent_pc_d   [2];
  logic [31:0] last_inst_q, last_inst_d;
  logic [31:0] last_pc_q, last_pc_d;

  logic pop;
  logic push;
  logic redirect_aligned;

  assign imem_addr        = {2'b00, pc_q[31:2]};
  assign out_valid        = (cnt_q != 2'd0);
  assign pop              = out_valid & out_ready;
  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);
  assign fetch_fault      = fault_q;
  assign fetch_state      = state_q;

  // Once empty, the outputs keep presenting the most recent head entry.
  assign out_inst = out_valid ? ent_inst_q[head_q] : last_inst_q;
  assign out_pc   = out_valid ? ent_pc_q[head_q]   : last_pc_q;

  always_comb begin
    push = 1'b0;
    if (state_q == StRun && !halt && !redirect_valid) begin
      push = (cnt_q < Full) || pop;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    last_inst_d = last_inst_q;
    last_pc_d   = last_pc_q;
    ent_inst_d  = ent_inst_q;
    ent_pc_d    = ent_pc_q;

    if (out_valid) begin
      last_inst_d = ent_inst_q[head_q];
      last_pc_d   = ent_pc_q[head_q];
    end

    if (redirect_valid) begin
      // Flush wins over any same-cycle pop; decode drops that beat itself.
      cnt_d  = 2'd0;
      head_d = 1'b0;
      tail_d = 1'b0;
      if (redirect_aligned) begin
        pc_d    = redirect_pc;
        fault_d = 1'b0;
        state_d = halt ? StHalted : StRun;
      end else begin
        fault_d = 1'b1;
        state_d = StFault;
      end
    end else begin
      case (state_q)
        StRun:    if (halt)  state_d = StHalted;
        StHalted: if (!halt) state_d = StRun;
        StFault:  state_d = StFault;
        default:  state_d = StRun;
      endcase

      if (push) begin
        ent_inst_d[tail_q] = imem_inst;
        ent_pc_d[tail_q]   = pc_q;
        tail_d             = ~tail_q;
        pc_d               = pc_q + 32'd4;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      fault_q     <= 1'b0;
      cnt_q       <= 2'd0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      last_inst_q <= 32'd0;
      last_pc_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      last_inst_q <= last_inst_d;
      last_pc_q   <= last_pc_d;
    end
  end

  // Payload storage needs no reset: it is only observed through a valid count.
  always_ff @(posedge clk) begin
    ent_inst_q <= ent_inst_d;
    ent_pc_q   <= ent_pc_d;
  end

endmodule
